// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter fed by a byte queue
// The queue is a separate module so the FSM only sees a valid/ready pop interface.

module uart_tx_fifo_queue #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [7:0]             m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Acceptance looks only at the registered count, so a full queue refuses
    // a byte even when a pop happens on the same edge.
    assign s_tready = count < (AW+1)'(DEPTH);
    assign m_tvalid = count != '0;
    assign m_tdata  = mem[rd_ptr];
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        TxD,
    output logic                        busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int DIV_COUNT = CLK_FREQ / BAUD_RATE;
    localparam int CW        = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          baud_last;
    logic          fifo_valid;
    logic          fifo_pop;
    logic [7:0]    fifo_data;

    assign baud_last = baud_cnt == CW'(DIV_COUNT - 1);
    // Popping at the end of the stop bit chains frames with no idle bit.
    assign fifo_pop  = fifo_valid && ((state == IDLE) || (state == STOP && baud_last));

    uart_tx_fifo_queue #(
        .DEPTH(FIFO_DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .s_tdata (tx_data),
        .s_tvalid(tx_valid),
        .s_tready(tx_ready),
        .m_tdata (fifo_data),
        .m_tvalid(fifo_valid),
        .m_tready(fifo_pop),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            TxD      <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    TxD      <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    if (fifo_pop) begin
                        shift <= fifo_data;
                        state <= START;
                        TxD   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        TxD      <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            TxD   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            TxD     <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        tx_done  <= 1'b1;
                        if (fifo_pop) begin
                            shift <= fifo_data;
                            state <= START;
                            TxD   <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - bench for uart_tx_fifo against a frame-level queue model
// The model tracks queued bytes and the remaining frame time; the line level is read from the frame bit vector.

module tb_uart_tx_fifo;
    localparam int DIV   = 16;
    localparam int FRAME = 10 * DIV;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       TxD;
    logic       busy;
    logic       tx_done;
    logic [4:0] fifo_count;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mq[$];
    int         left = 0;
    logic [7:0] cur = 8'h00;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_FREQ  (16),
        .BAUD_RATE (1),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .TxD       (TxD),
        .busy      (busy),
        .tx_done   (tx_done),
        .fifo_count(fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model by one edge, compare all outputs.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        logic       pop_ok;
        logic       acc;
        logic       exp_done;
        logic       exp_txd;
        logic [9:0] fr;
        int         p;
        reset    = r;
        tx_valid = v;
        tx_data  = d;
        @(posedge clk);
        exp_done = 1'b0;
        if (r) begin
            mq.delete();
            left = 0;
        end else begin
            exp_done = (left == 1);
            if (left > 0) left--;
            pop_ok = (left == 0) && (mq.size() > 0);
            acc    = v && (mq.size() < DEPTH);
            if (pop_ok) begin
                cur  = mq.pop_front();
                left = FRAME;
            end
            if (acc) mq.push_back(d);
        end
        exp_txd = 1'b1;
        if (left > 0) begin
            p       = FRAME - left;
            fr      = {1'b1, cur, 1'b0};
            exp_txd = fr[p / DIV];
        end
        #1;
        check("txd",   TxD,        exp_txd);
        check("busy",  busy,       left > 0);
        check("done",  tx_done,    exp_done);
        check("count", fifo_count, mq.size());
        check("ready", tx_ready,   mq.size() < DEPTH);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        // Reset held for three cycles
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        check("rst_txd",   TxD, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy",  busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_done",  tx_done, 0);

        // Single byte 0xA5 pushed at E0
        step(1'b1, 8'hA5, 1'b0);
        for (int i = 1; i <= 170; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (i == 1) begin
                check("single_start_txd",  TxD, 0);
                check("single_start_busy", busy, 1);
            end
            if (i == 161) check("single_done_e161", tx_done, 1);
        end
        check("single_end_txd", TxD, 1);

        // Back-to-back 0x00, 0xFF, 0x55
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        for (int i = 3; i <= 500; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (i == 161 || i == 321 || i == 481) begin
                check("b2b_done", tx_done, 1);
                if (i != 481) check("b2b_no_gap", TxD, 0);
            end
        end

        // Overflow: 18 pushes on consecutive cycles, the last one dropped
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 8'h10 + 8'(i), 1'b0);
            if (i == 16) begin
                check("ovf_count_full", fifo_count, 16);
                check("ovf_ready_low",  tx_ready, 0);
            end
        end
        check("ovf_count_after_drop", fifo_count, 16);
        idle(17 * FRAME + 20);

        // Push on the stop-completion edge with two bytes queued
        for (int i = 0; i <= 700; i++) begin
            if (i < 3)          step(1'b1, 8'hC0 + 8'(i), 1'b0);
            else if (i == 161)  step(1'b1, 8'h3C, 1'b0);
            else                step(1'b0, 8'h00, 1'b0);
            if (i == 161) begin
                check("pp_count", fifo_count, 2);
                check("pp_done",  tx_done, 1);
                check("pp_no_gap", TxD, 0);
            end
        end

        // Reset during DATA bit 3 of 0x81 with two bytes behind it
        step(1'b1, 8'h81, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        idle(67);
        step(1'b1, 8'h99, 1'b1);
        check("mrst_txd",   TxD, 1);
        check("mrst_count", fifo_count, 0);
        check("mrst_done",  tx_done, 0);
        check("mrst_busy",  busy, 0);
        step(1'b1, 8'h5A, 1'b0);
        for (int i = 1; i <= 170; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (i == 161) check("mrst_5a_done", tx_done, 1);
        end

        // Randomised pushes with occasional resets
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 299) == 0);
        end
        idle(18 * FRAME);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
